seven_seg_scanner: RTL

//  Time-multiplexed scan controller for the Nexys A7 8-digit common-anode display.

---
 rtl/seven_seg_scanner.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | seven_seg_scanner: multiplexed scan driver for a common-anode 7-seg display |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] c_cnt_last = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] c_idx_last = IW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  localparam phase_t c_phase_rst = (BLANK_CYCLES > 0) ? PH_BLANK : PH_DRIVE;

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  phase_t                  r_phase;
  logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data;
  logic [NUM_DIGITS-1:0]   r_pend_en, r_act_en;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp;

  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         w_idx_nxt;
  phase_t                w_phase_nxt;
  logic                  w_slot_wrap;
  logic                  w_boundary;
  logic [NUM_DIGITS-1:0] w_an;
  logic [6:0]            w_seg;
  logic                  w_dp;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  // Slot/frame counters and phase next-state; phase tracks the cnt value it will hold.
  always_comb begin
    w_slot_wrap = (r_cnt == c_cnt_last);
    w_boundary  = w_slot_wrap && (r_idx == c_idx_last);
    w_cnt_nxt   = w_slot_wrap ? '0 : r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    if (w_slot_wrap) begin
      w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + IW'(1);
    end
    w_phase_nxt = (int'(w_cnt_nxt) < BLANK_CYCLES) ? PH_BLANK : PH_DRIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= c_phase_rst;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  // Output next-values: dark unless driving an enabled digit.
  always_comb begin
    w_an  = '1;
    w_seg = 7'h7F;
    w_dp  = 1'b1;
    if (r_phase == PH_DRIVE) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if ((int'(r_idx) == k) && r_act_en[k]) begin
          w_an[k] = 1'b0;
          w_seg   = seg_decode(r_act_data[4*k +: 4]);
          w_dp    = ~r_act_dp[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pend_data <= '0;
      r_pend_en   <= '0;
      r_pend_dp   <= '0;
      r_act_data  <= '0;
      r_act_en    <= '0;
      r_act_dp    <= '0;
      an_out      <= '1;
      seg_out     <= 7'h7F;
      dp_out      <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      if (load) begin
        r_pend_data <= data_in;
        r_pend_en   <= digit_en;
        r_pend_dp   <= dp_in;
      end
      // Active snapshot only changes between frames so a scan never tears.
      if (w_boundary) begin
        r_act_data <= load ? data_in  : r_pend_data;
        r_act_en   <= load ? digit_en : r_pend_en;
        r_act_dp   <= load ? dp_in    : r_pend_dp;
      end
      an_out     <= w_an;
      seg_out    <= w_seg;
      dp_out     <= w_dp;
      frame_done <= w_boundary;
    end
  end

endmodule
`default_nettype wire
